// File: rtl/ppc2simulink_event_fifo_if.sv
// ppc2simulink_event_fifo_if: valid/ready event stream from the change-detect FIFO to its consumer
interface ppc2simulink_event_fifo_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] data;
  logic valid;
  logic ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/ppc2simulink_event_fifo.sv
// ppc2simulink_event_fifo: queues every change of a software register as an event in a small FIFO
// Define PPC2SIM_OVF_COUNT_EN to add the saturating ovf_count dropped-event counter port.
module ppc2simulink_event_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic [DATA_WIDTH-1:0] reg_in,
  ppc2simulink_event_fifo_if.master evt,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  input  logic                  clr_ovf
`ifdef PPC2SIM_OVF_COUNT_EN
  ,
  output logic [15:0]           ovf_count
`endif
);
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] prev_val;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic change, full, pop, push, drop;
  assign change = reg_in != prev_val;
  assign full = fifo_level == LW'(2**DEPTH_LOG2);
  assign evt.valid = fifo_level != '0;
  assign evt.data = mem[rd_ptr];
  assign pop = evt.valid & evt.ready;
  // a simultaneous pop frees the slot, so a full FIFO can still accept
  assign push = change & (!full | pop);
  assign drop = change & full & !pop;
  always_ff @(posedge user_clk)
    if (push) mem[wr_ptr] <= reg_in;
  always_ff @(posedge user_clk or posedge user_rst)
    if (user_rst) begin
      prev_val <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      overflow <= 1'b0;
    end else begin
      if (change) prev_val <= reg_in;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      overflow <= drop | (overflow & !clr_ovf);
    end
`ifdef PPC2SIM_OVF_COUNT_EN
  always_ff @(posedge user_clk or posedge user_rst)
    if (user_rst) ovf_count <= '0;
    else if (clr_ovf) ovf_count <= {15'd0, drop};
    else if (drop && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
`endif
endmodule

// File: tb/tb_ppc2simulink_event_fifo.sv
// tb_ppc2simulink_event_fifo: directed and random scoreboard bench for the register-change event FIFO
module tb_ppc2simulink_event_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  logic user_clk = 1'b0;
  logic user_rst = 1'b1;
  logic [DW-1:0] reg_in = '0;
  logic [2:0] fifo_level;
  logic overflow;
  logic clr_ovf = 1'b0;
  logic [15:0] ovf_cnt_obs;
  ppc2simulink_event_fifo_if #(.DATA_WIDTH(DW)) evt();
  int n_assert = 0;
  int n_fail = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] m_prev = '0;
  logic m_ovf = 1'b0;
  logic [15:0] m_cnt = '0;
`ifdef PPC2SIM_OVF_COUNT_EN
  logic [15:0] ovf_count;
  assign ovf_cnt_obs = ovf_count;
`else
  assign ovf_cnt_obs = '0;
`endif
  ppc2simulink_event_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(2)) dut (
    .user_clk(user_clk),
    .user_rst(user_rst),
    .reg_in(reg_in),
    .evt(evt),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .clr_ovf(clr_ovf)
`ifdef PPC2SIM_OVF_COUNT_EN
    ,
    .ovf_count(ovf_count)
`endif
  );
  always #5 user_clk = ~user_clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    sb.delete();
    m_prev = '0;
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask
  // advance one clock: update the model from current inputs, then compare after the edge
  task automatic tick(input string tag);
    logic chg, full, pop, push, drop;
    chg = reg_in != m_prev;
    full = sb.size() == DEPTH;
    pop = sb.size() != 0 && evt.ready;
    if (pop) begin
      check({tag, ".pop_data"}, evt.data, sb[0]);
      void'(sb.pop_front());
    end
    push = chg && (!full || pop);
    drop = chg && full && !pop;
    if (chg) m_prev = reg_in;
    if (push) sb.push_back(reg_in);
    m_ovf = drop | (m_ovf & !clr_ovf);
    m_cnt = clr_ovf ? {15'd0, drop} : (drop && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
    @(posedge user_clk);
    #1;
    check({tag, ".level"}, fifo_level, sb.size());
    check({tag, ".valid"}, evt.valid, sb.size() != 0);
    check({tag, ".overflow"}, overflow, m_ovf);
    if (sb.size() != 0) check({tag, ".head"}, evt.data, sb[0]);
`ifdef PPC2SIM_OVF_COUNT_EN
    check({tag, ".ovf_count"}, ovf_cnt_obs, m_cnt);
`endif
  endtask
  initial begin
    evt.ready = 1'b1;
    repeat (2) @(posedge user_clk);
    #1;
    check("reset.level", fifo_level, 0);
    check("reset.valid", evt.valid, 0);
    check("reset.overflow", overflow, 0);
    check("reset.ovf_count", ovf_cnt_obs, 0);
    user_rst = 1'b0;
    for (int i = 0; i < 10; i++) tick("idle_zero");
    check("idle.level", fifo_level, 0);
    reg_in = 32'hDEAD_BEEF;
    tick("beef_push");
    check("beef.valid", evt.valid, 1);
    check("beef.data", evt.data, 32'hDEAD_BEEF);
    tick("beef_pop");
    check("beef.empty", evt.valid, 0);
    evt.ready = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      reg_in = v;
      tick("burst");
    end
    check("burst.level", fifo_level, 4);
    check("burst.overflow", overflow, 1);
    check("burst.head", evt.data, 1);
`ifdef PPC2SIM_OVF_COUNT_EN
    check("burst.ovf_count", ovf_cnt_obs, 2);
`endif
    reg_in = 32'h55;
    evt.ready = 1'b1;
    tick("full_swap");
    check("swap.level", fifo_level, 4);
    for (int i = 0; i < 4; i++) tick("drain");
    check("drain.empty", fifo_level, 0);
    evt.ready = 1'b0;
    for (int v = 10; v <= 13; v++) begin
      reg_in = v;
      tick("refill");
    end
    reg_in = 14;
    clr_ovf = 1'b1;
    tick("drop_clr");
    check("drop_clr.overflow", overflow, 1);
`ifdef PPC2SIM_OVF_COUNT_EN
    check("drop_clr.ovf_count", ovf_cnt_obs, 1);
`endif
    tick("clr_only");
    check("clr_only.overflow", overflow, 0);
    check("clr_only.ovf_count", ovf_cnt_obs, 0);
    clr_ovf = 1'b0;
    user_rst = 1'b1;
    model_reset();
    @(posedge user_clk);
    #1;
    user_rst = 1'b0;
    for (int v = 21; v <= 23; v++) begin
      reg_in = v;
      tick("pre_rst");
    end
    check("pre_rst.level", fifo_level, 3);
    #3;
    user_rst = 1'b1;
    #1;
    check("async_rst.valid", evt.valid, 0);
    check("async_rst.level", fifo_level, 0);
    model_reset();
    @(posedge user_clk);
    #1;
    user_rst = 1'b0;
    tick("post_rst");
    check("post_rst.valid", evt.valid, 1);
    check("post_rst.data", evt.data, 23);
    for (int i = 0; i < 60; i++) begin
      reg_in = 32'(100 + $urandom_range(0, 3));
      evt.ready = 1'($urandom_range(0, 1));
      clr_ovf = ($urandom_range(0, 7) == 0);
      tick("random");
    end
    clr_ovf = 1'b0;
    evt.ready = 1'b1;
    for (int i = 0; i < 6; i++) tick("final_drain");
    check("final.level", fifo_level, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ppc2simulink_event_fifo.md
PPC2SIMULINK_EVENT_FIFO -- requirements
Module: ppc2simulink_event_fifo

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, as the width of the software register value and of each queued event.
REQ-002 The block SHALL take parameter DEPTH_LOG2, default 2, which sets FIFO depth to 2**DEPTH_LOG2 entries (default 4).
REQ-003 The block SHALL have user_clk, input, 1 bit: the single clock; all logic is rising-edge on user_clk.
REQ-004 The block SHALL have user_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have reg_in, input, DATA_WIDTH bits: the software register value in the user_clk domain; it changes atomically in one cycle.
REQ-006 The block SHALL have evt_data, output, DATA_WIDTH bits: the value at the FIFO head.
REQ-007 The block SHALL have evt_valid, output, 1 bit: the FIFO is non-empty and evt_data is meaningful.
REQ-008 The block SHALL have evt_ready, input, 1 bit: the consumer accepts the head entry when evt_valid and evt_ready are both high.
REQ-009 The block SHALL have fifo_level, output, DEPTH_LOG2+1 bits: the number of occupied entries.
REQ-010 The block SHALL have overflow, output, 1 bit: sticky, an event was dropped.
REQ-011 The block SHALL have clr_ovf, input, 1 bit: synchronous clear of overflow (and of ovf_count, when present).
REQ-012 The block SHALL have ovf_count, output, 16 bits: the dropped-event count; this port exists only with PPC2SIM_OVF_COUNT_EN.

Function
REQ-013 The block SHALL hold prev_val, a DATA_WIDTH register; a change event occurs in any cycle where reg_in != prev_val.
REQ-014 On a change event, prev_val SHALL load reg_in at that clock edge, so each distinct value produces exactly one event.
REQ-015 On a change event with FIFO not full, or full with a pop in the same cycle, reg_in SHALL be written at the tail at that edge.
REQ-016 Latency SHALL be one cycle: a change in cycle N gives evt_valid high in cycle N+1 when the FIFO was empty, with evt_data equal to the new value.
REQ-017 A pop (evt_valid and evt_ready both high) SHALL advance the head at the clock edge; evt_data shows the next entry in the following cycle.
REQ-018 evt_ready while evt_valid is low SHALL have no effect.
REQ-019 evt_data and evt_valid SHALL stay stable while evt_valid is high and evt_ready is low.
REQ-020 Push and pop in the same cycle SHALL leave fifo_level unchanged, and both operations SHALL take effect.
REQ-021 On a change event with FIFO full and no pop: the event SHALL be dropped, the FIFO contents unchanged, prev_val still updated, and overflow set.
REQ-022 Read and write pointers SHALL wrap modulo depth; full is fifo_level == 2**DEPTH_LOG2 and empty is fifo_level == 0.
REQ-023 If clr_ovf and a drop occur in the same cycle, the set SHALL win (overflow = 1).
REQ-024 reg_in changing every cycle SHALL produce one event per cycle, subject to capacity.

Reset
REQ-025 While user_rst is high, these SHALL be cleared: prev_val = 0, pointers = 0, fifo_level = 0, evt_valid = 0, overflow = 0, and ovf_count = 0.
REQ-026 evt_data after reset SHALL be don't-care while evt_valid = 0, so FIFO storage needs no reset.
REQ-027 Asserting reset mid-operation SHALL discard all queued events immediately.
REQ-028 After reset deassertion, a non-zero reg_in SHALL generate an event in the first active cycle.

Configuration
REQ-029 With the macro PPC2SIM_OVF_COUNT_EN defined: ovf_count SHALL increment by 1 per dropped event and saturate at 0xFFFF.
REQ-030 With PPC2SIM_OVF_COUNT_EN defined: clr_ovf SHALL zero ovf_count, and a drop in the same cycle SHALL give ovf_count = 1.
REQ-031 With PPC2SIM_OVF_COUNT_EN undefined: the ovf_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then reg_in = 0x0000_0000 held for 10 cycles, evt_ready = 1 -> evt_valid stays 0 and fifo_level stays 0.
REQ-033 reg_in = 0xDEAD_BEEF in cycle N with FIFO empty -> evt_valid = 1 and evt_data = 0xDEAD_BEEF in N+1; pop in N+1 -> evt_valid = 0 in N+2.
REQ-034 evt_ready = 0; reg_in steps through values 1..6 on consecutive cycles -> FIFO holds 1, 2, 3, 4; fifo_level = 4; overflow = 1; ovf_count = 2 (macro on); draining yields 1, 2, 3, 4 in order.
REQ-035 FIFO full; a change to 0x55 in the same cycle as a pop -> no drop, fifo_level stays 4, and the final entry read out is 0x55.
REQ-036 Drop and clr_ovf in the same cycle -> overflow = 1 and ovf_count = 1 (macro on); clr_ovf alone in the next cycle -> both read 0.
REQ-037 Three entries queued, then user_rst pulsed asynchronously mid-cycle -> evt_valid = 0 and fifo_level = 0 immediately, before the next clock edge.
